hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage RV32I core; successor to the plain combinational forwarding unit.
- Adds three things:
  - load-use stall detection
  - branch/jump flush
  - memory wait-state handling: a whole-pipe freeze with timeout on the LSU/peripheral handshake
- Optionally adds performance counters.
- Sits beside the stage modules in the pipeline top. Drives stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers and the E-stage operand muxes.

Parameters:
- REG_AW, 5, register address width.
- MEM_WAIT_MAX, 15, maximum wait cycles for i_mem_ack before forced release (1..255).
- CNT_W, 32, performance counter width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rs1_addr_d, i_rs2_addr_d  in  REG_AW  decode-stage source registers.
- i_rs1_addr_e, i_rs2_addr_e  in  REG_AW  execute-stage source registers.
- i_rd_addr_e  in  REG_AW  execute-stage destination.
- i_regwr_e  in  1  E-stage writes register.
- i_load_e  in  1  E-stage instruction is a load (ResultSrc = memory).
- i_rd_addr_m  in  REG_AW  M-stage destination.
- i_regwr_m  in  1  M-stage writes register.
- i_rd_addr_w  in  REG_AW  W-stage destination.
- i_regwr_w  in  1  W-stage writes register.
- i_pcsrc_e  in  1  taken branch or jump resolved in E.
- i_mem_req_m  in  1  M-stage memory/IO access needing acknowledge.
- i_mem_ack  in  1  LSU acknowledge.
- i_insn_vld_w  in  1  instruction retiring in W.
- o_fwd_a_e, o_fwd_b_e  out  2  operand select: 00 register file, 10 ALU result from M, 01 result from W.
- o_stall_f, o_stall_d, o_stall_e, o_stall_m  out  1  hold the corresponding pipeline register.
- o_flush_d, o_flush_e, o_flush_w  out  1  load a bubble (insn_vld=0, RegWrite=0, MemWrite=0) into F/D, D/E or M/W.
- o_mem_timeout  out  1  sticky: a memory access was force-released.
- o_cnt_cycle, o_cnt_retired, o_cnt_stall, o_cnt_flush  out  CNT_W  performance counters.

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM to RUN; wait counter 0; o_mem_timeout 0; all counters 0.
  - All stall/flush outputs 0; forward selects 00.
- Forwarding (combinational, both operands independently):
  - Select 10 if i_regwr_m, i_rd_addr_m!=0 and i_rd_addr_m matches the E source.
  - Else select 01 if i_regwr_w, i_rd_addr_w!=0 and i_rd_addr_w matches the E source.
  - Else 00. M has priority over W. x0 is never forwarded.
- Load-use: hazard when i_load_e, i_rd_addr_e!=0 and i_rd_addr_e equals i_rs1_addr_d or i_rs2_addr_d.
  - Response: o_stall_f=1, o_stall_d=1, o_flush_e=1 for exactly one cycle.
- Branch flush: i_pcsrc_e=1 gives o_flush_d=1 and o_flush_e=1 for that cycle. F is not stalled, so the redirect loads.
- FSM RUN:
  - If i_mem_req_m && !i_mem_ack: freeze the pipe this cycle and go to WAIT with wait counter=1.
    - Freeze = o_stall_f/d/e/m=1 and o_flush_w=1.
  - i_mem_req_m && i_mem_ack in the same cycle gives no freeze.
- FSM WAIT:
  - Freeze held every cycle.
  - i_mem_ack=1: release (no freeze this cycle); go to RUN.
  - Else if wait counter == MEM_WAIT_MAX: release; set o_mem_timeout; go to RUN. The LSU returns 0 data on timeout.
  - Else increment the wait counter.
- Priority: freeze > branch flush > load-use.
  - During freeze, i_pcsrc_e and load-use are ignored. The instructions are held, so both are re-evaluated on release.
  - Branch and load-use in the same cycle: branch flush only, no stall. The dependent instruction is squashed anyway.
- Whole-pipe stall is never combined with a flush of the same register except o_flush_w. The bubble into W prevents a double retire/write.
- Reset mid-WAIT returns to RUN immediately, with no timeout flag.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - o_cnt_cycle increments every cycle.
  - o_cnt_retired increments when i_insn_vld_w=1.
  - o_cnt_stall increments on any cycle with o_stall_f=1.
  - o_cnt_flush increments on any cycle with o_flush_e=1 caused by i_pcsrc_e.
  - All counters wrap modulo 2^CNT_W.
- HAZARD_PERF_CNT_EN undefined: no counter flops; all four counter outputs tied to 0.

Test Plan:
- Forwarding: regwr_m=1, rd_m=5, regwr_w=1, rd_w=5, rs1_e=5, rs2_e=0 -> fwd_a=10, fwd_b=00; repeat with rd_m=0 -> fwd_a=01.
- Load-use: load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for 1 cycle; with rd_e=0 -> no stall.
- Branch + load-use same cycle: pcsrc_e=1, load_e=1, rd_e=3, rs1_d=3 -> flush_d=flush_e=1, stall_f=0.
- Memory wait: mem_req_m=1, ack rises after 4 cycles -> freeze 4 cycles (stall_f..m=1, flush_w=1), release on ack cycle, mem_timeout=0.
- Timeout: MEM_WAIT_MAX=15, ack never rises -> freeze exactly 15 cycles, release, o_mem_timeout=1 and sticky; i_rst_n low mid-WAIT -> outputs 0 asynchronously.
- With HAZARD_PERF_CNT_EN: 100 cycles, 60 retires, 1 load-use, 2 branches -> cycle=100, retired=60, stall=1, flush=2; undefined -> all 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: forwarding, load-use stall, branch flush, memory freeze.
// Optional performance counters when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
   parameter int REG_AW       = 5,
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [REG_AW-1:0] i_rs1_addr_d,
   input  logic [REG_AW-1:0] i_rs2_addr_d,
   input  logic [REG_AW-1:0] i_rs1_addr_e,
   input  logic [REG_AW-1:0] i_rs2_addr_e,
   input  logic [REG_AW-1:0] i_rd_addr_e,
   input  logic              i_regwr_e,
   input  logic              i_load_e,
   input  logic [REG_AW-1:0] i_rd_addr_m,
   input  logic              i_regwr_m,
   input  logic [REG_AW-1:0] i_rd_addr_w,
   input  logic              i_regwr_w,
   input  logic              i_pcsrc_e,
   input  logic              i_mem_req_m,
   input  logic              i_mem_ack,
   input  logic              i_insn_vld_w,
   output logic [1:0]        o_fwd_a_e,
   output logic [1:0]        o_fwd_b_e,
   output logic              o_stall_f,
   output logic              o_stall_d,
   output logic              o_stall_e,
   output logic              o_stall_m,
   output logic              o_flush_d,
   output logic              o_flush_e,
   output logic              o_flush_w,
   output logic              o_mem_timeout,
   output logic [CNT_W-1:0]  o_cnt_cycle,
   output logic [CNT_W-1:0]  o_cnt_retired,
   output logic [CNT_W-1:0]  o_cnt_stall,
   output logic [CNT_W-1:0]  o_cnt_flush
);

   typedef enum logic {
      ST_RUN,
      ST_WAIT
   } state_t;

   localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       timeout_q;

   logic       m_fwd_ok;
   logic       w_fwd_ok;
   logic       lu_hit;
   logic       freeze;
   logic       br_flush;
   logic       lu_stall;

   // i_regwr_e is part of the E-stage bundle but load-use only needs i_load_e
   logic unused_regwr_e;
   assign unused_regwr_e = i_regwr_e;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_RUN;
         wait_cnt  <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (i_mem_req_m && !i_mem_ack) begin
                  state    <= ST_WAIT;
                  wait_cnt <= 8'd1;
               end
            end
            ST_WAIT: begin
               if (i_mem_ack) begin
                  state    <= ST_RUN;
                  wait_cnt <= 8'd0;
               end else if (wait_cnt == WAIT_MAX) begin
                  state     <= ST_RUN;
                  wait_cnt  <= 8'd0;
                  timeout_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: begin
               state    <= ST_RUN;
               wait_cnt <= 8'd0;
            end
         endcase
      end
   end

   assign m_fwd_ok = i_regwr_m && (i_rd_addr_m != '0);
   assign w_fwd_ok = i_regwr_w && (i_rd_addr_w != '0);

   always_comb begin
      o_fwd_a_e = 2'b00;
      o_fwd_b_e = 2'b00;
      if (i_rst_n) begin
         if (m_fwd_ok && i_rd_addr_m == i_rs1_addr_e)
            o_fwd_a_e = 2'b10;
         else if (w_fwd_ok && i_rd_addr_w == i_rs1_addr_e)
            o_fwd_a_e = 2'b01;
         if (m_fwd_ok && i_rd_addr_m == i_rs2_addr_e)
            o_fwd_b_e = 2'b10;
         else if (w_fwd_ok && i_rd_addr_w == i_rs2_addr_e)
            o_fwd_b_e = 2'b01;
      end
   end

   assign lu_hit = i_load_e && (i_rd_addr_e != '0) &&
                   (i_rd_addr_e == i_rs1_addr_d ||
                    i_rd_addr_e == i_rs2_addr_d);

   // Reset gates every control so a held request cannot freeze during reset
   always_comb begin
      freeze = 1'b0;
      if (i_rst_n) begin
         if (state == ST_RUN)
            freeze = i_mem_req_m && !i_mem_ack;
         else
            freeze = !i_mem_ack && (wait_cnt != WAIT_MAX);
      end
   end

   assign br_flush = i_rst_n && !freeze && i_pcsrc_e;
   assign lu_stall = i_rst_n && !freeze && !i_pcsrc_e && lu_hit;

   assign o_stall_f     = freeze | lu_stall;
   assign o_stall_d     = freeze | lu_stall;
   assign o_stall_e     = freeze;
   assign o_stall_m     = freeze;
   assign o_flush_d     = br_flush;
   assign o_flush_e     = br_flush | lu_stall;
   assign o_flush_w     = freeze;
   assign o_mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_cycle;
   logic [CNT_W-1:0] cnt_retired;
   logic [CNT_W-1:0] cnt_stall;
   logic [CNT_W-1:0] cnt_flush;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_cycle   <= '0;
         cnt_retired <= '0;
         cnt_stall   <= '0;
         cnt_flush   <= '0;
      end else begin
         cnt_cycle <= cnt_cycle + 1'b1;
         if (i_insn_vld_w)
            cnt_retired <= cnt_retired + 1'b1;
         if (o_stall_f)
            cnt_stall <= cnt_stall + 1'b1;
         if (br_flush)
            cnt_flush <= cnt_flush + 1'b1;
      end
   end

   assign o_cnt_cycle   = cnt_cycle;
   assign o_cnt_retired = cnt_retired;
   assign o_cnt_stall   = cnt_stall;
   assign o_cnt_flush   = cnt_flush;
`else
   logic unused_insn_vld;
   assign unused_insn_vld = i_insn_vld_w;

   assign o_cnt_cycle   = '0;
   assign o_cnt_retired = '0;
   assign o_cnt_stall   = '0;
   assign o_cnt_flush   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, freeze, timeout.
// Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e;
   logic [4:0] rd_e, rd_m, rd_w;
   logic       regwr_e, load_e, regwr_m, regwr_w;
   logic       pcsrc_e, mem_req_m, mem_ack, insn_vld_w;
   logic [1:0] fwd_a, fwd_b;
   logic       stall_f, stall_d, stall_e, stall_m;
   logic       flush_d, flush_e, flush_w;
   logic       mem_timeout;
   logic [31:0] cnt_cycle, cnt_retired, cnt_stall, cnt_flush;

   int errors = 0;
   int checks = 0;

   localparam logic [6:0] C_NONE   = 7'b0000000;
   localparam logic [6:0] C_FREEZE = 7'b1111001;
   localparam logic [6:0] C_LU     = 7'b1100010;
   localparam logic [6:0] C_BR     = 7'b0000110;

   logic [6:0] ctl;
   assign ctl = {stall_f, stall_d, stall_e, stall_m,
                 flush_d, flush_e, flush_w};

   hazard_ctrl #(
      .REG_AW(5), .MEM_WAIT_MAX(15), .CNT_W(32)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_rs1_addr_d(rs1_d), .i_rs2_addr_d(rs2_d),
      .i_rs1_addr_e(rs1_e), .i_rs2_addr_e(rs2_e),
      .i_rd_addr_e(rd_e), .i_regwr_e(regwr_e), .i_load_e(load_e),
      .i_rd_addr_m(rd_m), .i_regwr_m(regwr_m),
      .i_rd_addr_w(rd_w), .i_regwr_w(regwr_w),
      .i_pcsrc_e(pcsrc_e), .i_mem_req_m(mem_req_m),
      .i_mem_ack(mem_ack), .i_insn_vld_w(insn_vld_w),
      .o_fwd_a_e(fwd_a), .o_fwd_b_e(fwd_b),
      .o_stall_f(stall_f), .o_stall_d(stall_d),
      .o_stall_e(stall_e), .o_stall_m(stall_m),
      .o_flush_d(flush_d), .o_flush_e(flush_e), .o_flush_w(flush_w),
      .o_mem_timeout(mem_timeout),
      .o_cnt_cycle(cnt_cycle), .o_cnt_retired(cnt_retired),
      .o_cnt_stall(cnt_stall), .o_cnt_flush(cnt_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic clear_in();
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
      rd_e = 0; rd_m = 0; rd_w = 0;
      regwr_e = 0; load_e = 0; regwr_m = 0; regwr_w = 0;
      pcsrc_e = 0; mem_req_m = 0; mem_ack = 0; insn_vld_w = 0;
   endtask

   // drive at negedge, sample 2 time units later, well before posedge
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      clear_in();
      rst_n = 1'b0;
      regwr_m = 1; rd_m = 5; rs1_e = 5;
      mem_req_m = 1; pcsrc_e = 1;
      load_e = 1; rd_e = 7; rs2_d = 7;
      #12;
      chk("rst_ctl", 32'(ctl), 32'(C_NONE));
      chk("rst_fwd_a", 32'(fwd_a), 32'd0);
      chk("rst_timeout", 32'(mem_timeout), 32'd0);
      chk("rst_cnt", cnt_cycle | cnt_retired | cnt_stall | cnt_flush, 32'd0);

      step(); clear_in(); rst_n = 1'b1;
      #2 chk("idle_ctl", 32'(ctl), 32'(C_NONE));

      // forwarding
      step();
      regwr_m = 1; rd_m = 5; regwr_w = 1; rd_w = 5; rs1_e = 5; rs2_e = 0;
      #2 chk("fwd_a_m", 32'(fwd_a), 32'd2);
      chk("fwd_b_x0", 32'(fwd_b), 32'd0);
      step(); rd_m = 0;
      #2 chk("fwd_a_w", 32'(fwd_a), 32'd1);
      step(); rd_m = 9; rs1_e = 3; rs2_e = 9;
      #2 chk("fwd_a_none", 32'(fwd_a), 32'd0);
      chk("fwd_b_m", 32'(fwd_b), 32'd2);
      step(); regwr_m = 0; rd_w = 9;
      #2 chk("fwd_b_w", 32'(fwd_b), 32'd1);
      step(); regwr_w = 0;
      #2 chk("fwd_b_nowr", 32'(fwd_b), 32'd0);

      // load-use
      step(); clear_in(); load_e = 1; rd_e = 7; rs2_d = 7;
      #2 chk("lu_rs2", 32'(ctl), 32'(C_LU));
      step(); load_e = 0; rd_e = 0;
      #2 chk("lu_gone", 32'(ctl), 32'(C_NONE));
      step(); load_e = 1; rd_e = 0; rs2_d = 0;
      #2 chk("lu_x0", 32'(ctl), 32'(C_NONE));
      step(); load_e = 0; regwr_e = 1; rd_e = 4; rs1_d = 4;
      #2 chk("lu_noload", 32'(ctl), 32'(C_NONE));
      step(); load_e = 1;
      #2 chk("lu_rs1", 32'(ctl), 32'(C_LU));

      // branch + load-use
      step(); clear_in(); pcsrc_e = 1; load_e = 1; rd_e = 3; rs1_d = 3;
      #2 chk("br_lu", 32'(ctl), 32'(C_BR));
      step(); clear_in(); pcsrc_e = 1;
      #2 chk("br_only", 32'(ctl), 32'(C_BR));

      // memory wait, ack on fifth cycle
      step(); clear_in(); mem_req_m = 1; mem_ack = 1;
      #2 chk("req_ack_same", 32'(ctl), 32'(C_NONE));
      for (int i = 0; i < 4; i++) begin
         step(); mem_ack = 0;
         pcsrc_e = (i == 1); load_e = (i == 2); rd_e = 6; rs1_d = 6;
         #2 chk($sformatf("wait_frz%0d", i), 32'(ctl), 32'(C_FREEZE));
      end
      step(); clear_in(); mem_req_m = 1; mem_ack = 1;
      #2 chk("wait_rel", 32'(ctl), 32'(C_NONE));
      step(); clear_in();
      #2 chk("wait_run", 32'(ctl), 32'(C_NONE));
      chk("wait_noto", 32'(mem_timeout), 32'd0);

      // timeout: 15 frozen cycles, release on the 16th
      for (int i = 0; i < 15; i++) begin
         step(); mem_req_m = 1;
         #2 chk($sformatf("to_frz%0d", i), 32'(ctl), 32'(C_FREEZE));
      end
      step();
      #2 chk("to_rel", 32'(ctl), 32'(C_NONE));
      chk("to_flag_pre", 32'(mem_timeout), 32'd0);
      step(); clear_in();
      #2 chk("to_flag", 32'(mem_timeout), 32'd1);
      chk("to_run", 32'(ctl), 32'(C_NONE));
      step(); step(); step();
      #2 chk("to_sticky", 32'(mem_timeout), 32'd1);

      // reset in the middle of WAIT
      step(); mem_req_m = 1;
      #2 chk("rw_frz0", 32'(ctl), 32'(C_FREEZE));
      step();
      #2 chk("rw_frz1", 32'(ctl), 32'(C_FREEZE));
      rst_n = 1'b0;
      #1 chk("rw_ctl", 32'(ctl), 32'(C_NONE));
      chk("rw_to", 32'(mem_timeout), 32'd0);
      step(); rst_n = 1'b1;
      #2 chk("rw_runfrz", 32'(ctl), 32'(C_FREEZE));
      step(); mem_ack = 1;
      #2 chk("rw_rel", 32'(ctl), 32'(C_NONE));

      // counters: 100 cycles, 60 retires, 1 load-use, 2 branches
      step(); clear_in(); rst_n = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         rst_n = 1'b1;
         clear_in();
         insn_vld_w = (i < 60);
         if (i == 10) begin load_e = 1; rd_e = 8; rs2_d = 8; end
         if (i == 20 || i == 30) pcsrc_e = 1;
      end
      step(); clear_in();
      #2;
`ifdef HAZARD_PERF_CNT_EN
      chk("cnt_cycle", cnt_cycle, 32'd100);
      chk("cnt_retired", cnt_retired, 32'd60);
      chk("cnt_stall", cnt_stall, 32'd1);
      chk("cnt_flush", cnt_flush, 32'd2);
`else
      chk("cnt_cycle", cnt_cycle, 32'd0);
      chk("cnt_retired", cnt_retired, 32'd0);
      chk("cnt_stall", cnt_stall, 32'd0);
      chk("cnt_flush", cnt_flush, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
